// File: rtl/arb_pkg.sv
// arb_pkg: shared encodings and default widths for the memory arbiter
package arb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch, load/store and memory-side signals of the arbiter
interface imem_dmem_arbiter_if
  import arb_pkg::*;
#(
  parameter int AW = arb_pkg::AW,
  parameter int DW = arb_pkg::DW
);
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;
  logic            i_err;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_err;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts access cycles and flags the last one allowed before abort
module arb_watchdog #(
  parameter int TIMEOUT = 64
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  // Cycle counter, restarted on every grant so each access gets the full budget
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between fetch and load/store paths
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int AW              = arb_pkg::AW,
  parameter int DW              = arb_pkg::DW,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
)(
  input logic               clk,
  input logic               rst,
  imem_dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
  state_t          r_state, w_next;
  owner_t          r_owner;
  logic [SW-1:0]   r_streak;
  logic            r_mem_req, r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_wstrb;
  logic            r_i_rvalid, r_i_err, r_d_rvalid, r_d_err;
  logic [DW-1:0]   r_i_rdata, r_d_rdata;
  logic            w_idle, w_i_gnt, w_d_gnt, w_ok, w_expired, w_to, w_done;
  assign w_idle  = r_state == ST_IDLE;
  assign w_i_gnt = w_idle && bus.i_req && (!bus.d_req || r_streak == SMAX);
  assign w_d_gnt = w_idle && bus.d_req && !w_i_gnt;
  assign w_ok    = !w_idle && bus.mem_ready;
  assign w_to    = w_expired && !bus.mem_ready;
  assign w_done  = w_ok || w_to;
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .i_clr(w_i_gnt || w_d_gnt),
    .i_en(!w_idle),
    .o_expired(w_expired)
  );
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // Next state: IDLE leaves on any grant, ACCESS returns on completion or timeout
  always_comb begin
    w_next = w_idle ? ((w_i_gnt || w_d_gnt) ? ST_ACCESS : ST_IDLE) : (w_done ? ST_IDLE : ST_ACCESS);
  end
  // Data-grant streak; only counts while a fetch is actually being starved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_streak <= '0;
    else if (w_i_gnt) r_streak <= '0;
    else if (w_d_gnt) r_streak <= !bus.i_req ? '0 : (r_streak == SMAX ? SMAX : r_streak + 1'b1);
  end
  // Access latching on grant and response capture on completion or abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_FETCH;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_i_rvalid  <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (w_i_gnt || w_d_gnt) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_d_gnt && bus.d_we;
        r_mem_addr  <= w_d_gnt ? bus.d_addr : bus.i_addr;
        r_mem_wdata <= w_d_gnt ? bus.d_wdata : '0;
        r_mem_wstrb <= (w_d_gnt && bus.d_we) ? bus.d_wstrb : '0;
        r_owner     <= w_d_gnt ? OWN_DATA : OWN_FETCH;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_owner == OWN_FETCH) begin
          r_i_rvalid <= 1'b1;
          r_i_err    <= w_to;
          r_i_rdata  <= w_ok ? bus.mem_rdata : '0;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= w_to;
          r_d_rdata  <= (w_ok && !r_mem_we) ? bus.mem_rdata : '0;
        end
      end
    end
  end
  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.i_rvalid  = r_i_rvalid;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_err     = r_i_err;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_err     = r_d_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.busy      = !w_idle || bus.i_req || bus.d_req;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed scoreboard bench for the fetch/data memory arbiter
module tb_imem_dmem_arbiter;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int delay = 0;
  bit stall = 1'b0;
  int mcnt = 0;
  logic [31:0] mem [logic [31:0]];
  exp_t iq[$];
  exp_t dq[$];
  imem_dmem_arbiter_if bus ();
  imem_dmem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  // Memory model: ready after 'delay' access cycles, never while stalled
  always @(negedge clk) begin
    if (rst || !bus.mem_req) begin
      mcnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
    end else begin
      bus.mem_ready = !stall && (mcnt == delay);
      if (bus.mem_ready) begin
        if (bus.mem_we) begin
          logic [31:0] w;
          w = rd(bus.mem_addr);
          for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
          mem[bus.mem_addr] = w;
        end
        bus.mem_rdata = bus.mem_we ? 32'hFFFF_FFFF : rd(bus.mem_addr);
      end
      mcnt++;
    end
  end
  // Monitor: compare every response pulse against the scoreboard
  always @(negedge clk) begin
    if (bus.i_rvalid) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL i_unexpected: got i_rvalid=1 expected no fetch response");
      end else begin
        exp_t e;
        e = iq.pop_front();
        chk("i_rdata", bus.i_rdata, e.rdata);
        chk("i_err", {31'b0, bus.i_err}, {31'b0, e.err});
      end
    end
    if (bus.d_rvalid) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_unexpected: got d_rvalid=1 expected no data response");
      end else begin
        exp_t e;
        e = dq.pop_front();
        chk("d_rdata", bus.d_rdata, e.rdata);
        chk("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
      end
    end
  end
  task automatic issue(input logic isd, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] er, input logic ee);
    bit g = 1'b0;
    if (isd) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_wstrb = ws;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = a;
    end
    for (int k = 0; k < 20 && !g; k++) begin
      #1;
      g = isd ? bus.d_gnt : bus.i_gnt;
      if (!g) cyc();
    end
    chk(isd ? "d_grant" : "i_grant", {31'b0, g}, 32'd1);
    if (g) begin
      if (isd) dq.push_back('{er, ee});
      else iq.push_back('{er, ee});
    end
    cyc();
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
  endtask
  task automatic drain(input string name);
    for (int k = 0; k < 50 && (iq.size() != 0 || dq.size() != 0); k++) cyc();
    chk(name, iq.size() + dq.size(), 32'd0);
  endtask
  initial begin
    int n;
    logic [9:0] seq;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    mem[32'h10]  = 32'h0050_0093;
    mem[32'h100] = 32'h0000_002A;
    mem[32'h104] = 32'h1122_3344;
    mem[32'h200] = 32'h0000_0055;
    mem[32'h20]  = 32'h1234_5678;
    repeat (2) cyc();
    chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wstrb", {28'b0, bus.mem_wstrb}, 0);
    chk("rst_i_rvalid", {31'b0, bus.i_rvalid}, 0);
    chk("rst_d_rvalid", {31'b0, bus.d_rvalid}, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    #1;
    chk("t1_i_gnt", {31'b0, bus.i_gnt}, 1);
    chk("t1_d_gnt", {31'b0, bus.d_gnt}, 0);
    iq.push_back('{32'h0050_0093, 1'b0});
    cyc();
    bus.i_req = 1'b0;
    chk("t1_mem_req", {31'b0, bus.mem_req}, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    chk("t1_mem_wstrb", {28'b0, bus.mem_wstrb}, 0);
    chk("t1_busy", {31'b0, bus.busy}, 1);
    cyc();
    chk("t1_i_rvalid", {31'b0, bus.i_rvalid}, 1);
    chk("t1_mem_req_drop", {31'b0, bus.mem_req}, 0);
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    #1;
    chk("t2_d_gnt", {31'b0, bus.d_gnt}, 1);
    chk("t2_i_gnt", {31'b0, bus.i_gnt}, 0);
    dq.push_back('{32'd42, 1'b0});
    cyc();
    bus.d_req = 1'b0;
    chk("t2_i_gnt_access", {31'b0, bus.i_gnt}, 0);
    chk("t2_mem_addr", bus.mem_addr, 32'h100);
    cyc();
    chk("t2_d_rvalid", {31'b0, bus.d_rvalid}, 1);
    chk("t2_i_gnt_turn", {31'b0, bus.i_gnt}, 1);
    iq.push_back('{32'h0050_0093, 1'b0});
    cyc();
    bus.i_req = 1'b0;
    chk("t2_mem_addr_f", bus.mem_addr, 32'h10);
    drain("t2_drain");
    delay = 3;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h104;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
    #1;
    chk("t3_d_gnt", {31'b0, bus.d_gnt}, 1);
    dq.push_back('{32'h0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.d_req = 1'b0;
      chk("t3_mem_req", {31'b0, bus.mem_req}, 1);
      chk("t3_mem_we", {31'b0, bus.mem_we}, 1);
      chk("t3_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'h3);
      chk("t3_mem_addr", bus.mem_addr, 32'h104);
      chk("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    end
    cyc();
    chk("t3_d_rvalid", {31'b0, bus.d_rvalid}, 1);
    chk("t3_mem_req_drop", {31'b0, bus.mem_req}, 0);
    delay = 0;
    issue(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 32'h1122_BEEF, 1'b0);
    drain("t3_drain");
    n = 0;
    seq = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    for (int k = 0; k < 60 && n < 10; k++) begin
      #1;
      if (bus.d_gnt || bus.i_gnt) begin
        seq = {seq[8:0], bus.d_gnt};
        n++;
        if (bus.d_gnt) dq.push_back('{32'h55, 1'b0});
        else iq.push_back('{32'h0050_0093, 1'b0});
      end
      cyc();
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    chk("t4_grants", n, 10);
    chk("t4_sequence", {22'b0, seq}, {22'b0, 10'b1111011110});
    drain("t4_drain");
    stall = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    #1;
    chk("t5_d_gnt", {31'b0, bus.d_gnt}, 1);
    dq.push_back('{32'h0, 1'b1});
    for (int k = 0; k < 8; k++) begin
      cyc();
      bus.d_req = 1'b0;
      chk("t5_mem_req_held", {31'b0, bus.mem_req}, 1);
    end
    cyc();
    chk("t5_mem_req_drop", {31'b0, bus.mem_req}, 0);
    chk("t5_d_rvalid", {31'b0, bus.d_rvalid}, 1);
    stall = 1'b0;
    mem[32'h300] = 32'hCAFE_0001;
    issue(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
    drain("t5_drain");
    delay = 3;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    #1;
    chk("t6_i_gnt", {31'b0, bus.i_gnt}, 1);
    cyc();
    bus.i_req = 1'b0;
    chk("t6_mem_req", {31'b0, bus.mem_req}, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("t6_rst_busy", {31'b0, bus.busy}, 0);
    chk("t6_rst_i_rvalid", {31'b0, bus.i_rvalid}, 0);
    repeat (2) begin
      cyc();
      chk("t6_no_rvalid", {31'b0, bus.i_rvalid}, 0);
    end
    rst = 1'b0;
    delay = 0;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    drain("t6_drain");
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Arbitrates requests and sequences each memory access with a ready handshake.
- Returns read data or write completion to the winning requester.
- Exposes `busy` so the core can stall PC/writeback while an access is in flight.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; must be a multiple of 8.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced; minimum 1.
- TIMEOUT, 64, cycles in ACCESS without mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- i_req  input  1  fetch request; held until granted.
- i_addr  input  AW  fetch address.
- i_gnt  output  1  fetch request accepted this cycle (combinational, IDLE only).
- i_rvalid  output  1  one-cycle pulse: i_rdata/i_err valid.
- i_rdata  output  DW  fetched instruction word.
- i_err  output  1  fetch timed out (valid with i_rvalid).
- d_req  input  1  data request; held until granted.
- d_we  input  1  1=store, 0=load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_wstrb  input  DW/8  byte enables for store.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  one-cycle completion pulse, for both load and store.
- d_rdata  output  DW  load data; 0 for stores.
- d_err  output  1  data access timed out.
- mem_req  output  1  memory access active; held until mem_ready.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_wstrb  output  DW/8  memory byte enables; 0 on reads.
- mem_ready  input  1  memory completed access this cycle.
- mem_rdata  input  DW  read data, valid with mem_ready.
- busy  output  1  high when state is not IDLE or a request is pending.

Behaviour:
- States: IDLE and ACCESS. Owner register: FETCH or DATA.
- Reset (async): state=IDLE; all outputs 0, including mem_*, *_gnt, *_rvalid, *_rdata and *_err; streak=0; timer=0.
- IDLE arbitration (combinational gnt):
  - Data wins by default.
  - Fetch wins if only i_req is high, or if i_req is high and streak==MAX_DATA_STREAK.
- On grant:
  - Latch addr/we/wdata/wstrb from the winner into the mem_* registers; mem_wstrb=0 and mem_we=0 for fetch.
  - Set owner and go to ACCESS. mem_req rises the next cycle.
- Streak counter:
  - Data grant with i_req high: streak+1, saturating at MAX_DATA_STREAK.
  - Fetch grant, or data grant with i_req low: streak=0.
- ACCESS:
  - mem_* outputs stay stable until the cycle mem_ready=1.
  - On that edge: mem_req goes to 0; the owner's rdata register captures mem_rdata (stores capture 0); the owner's rvalid pulses for exactly the next cycle with err=0; state returns to IDLE.
  - Minimum latency from gnt to rvalid is 2 cycles (mem_ready in the first ACCESS cycle).
- Back-to-back: new arbitration may grant in the same cycle rvalid pulses, since state is IDLE then. Turnaround is 1 cycle.
- Watchdog (TIMEOUT>0):
  - Timer counts ACCESS cycles and clears on entry to ACCESS.
  - When it reaches TIMEOUT with no mem_ready: drop mem_req, pulse owner rvalid with err=1 and rdata=0, return to IDLE.
  - mem_ready in the same cycle as expiry: treated as success.
- mem_ready while IDLE is ignored.
- i_rdata and d_rdata hold their last value between pulses.
- Requests withdrawn before grant are simply not granted; no state change.
- Reset mid-ACCESS aborts without any rvalid pulse. The memory model must tolerate mem_req dropping.

Decomposition:
- Shared package arb_pkg holds:
  - state encodings ST_IDLE and ST_ACCESS
  - owner encodings OWN_FETCH and OWN_DATA
  - default width constants AW and DW
- Sub-module arb_watchdog: TIMEOUT counter with clear/enable inputs and an expired output. Instantiated once.
- All other logic lives in the top module.

Test Plan:
- Fetch only: i_req at i_addr=0x10, memory returns 0x00500093 with 0-cycle delay. Expect i_gnt in the request cycle, mem_req one cycle later, i_rvalid 2 cycles after gnt with i_rdata=0x00500093.
- Simultaneous i_req and d_req (load at 0x100, data 0x2A). Expect d_gnt first and d_rdata=42; i_gnt in the cycle d_rvalid pulses.
- Store with d_wstrb=4'b0011 at 0x104, d_wdata=0xDEADBEEF, memory delay 3. Expect mem_we=1, mem_wstrb=0011, mem_* stable for 4 cycles, then d_rvalid=1 with d_rdata=0.
- Continuous d_req with i_req held high, MAX_DATA_STREAK=4. Expect exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- TIMEOUT=8 and memory never asserts ready. Expect mem_req high for 8 cycles, then drop, then d_rvalid=1, d_err=1, d_rdata=0. The next request succeeds normally.
- Assert rst in the 2nd ACCESS cycle. Expect immediate mem_req=0, no rvalid, busy=0; a post-reset fetch completes correctly.
